// File: rtl/deser_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the nibble deserializer slice: FSM state encoding,
// serial direction constants and the bit-counter width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package deser_pkg;

  // IDLE: no bits of the current word received yet.
  // RECV: a word is partially received.
  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Serial bit order of a word.
  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

  // Bit counter must hold 0..WIDTH (WIDTH is the parity-bit slot).
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nibble_deserializer_if.sv
// ---------------------------------------------------------------------------
// nibble_deserializer_if
// Bundles the serial input side and the valid/ready word output side of the
// deserializer.
//   sin, sin_valid, dir : serial bit, bit strobe, word bit order
//   d, d_valid, d_ready : assembled word with valid/ready handshake
// Modports:
//   slave  : the deserializer (consumes serial bits, produces words)
//   master : the environment (drives serial bits, consumes words)
// ---------------------------------------------------------------------------
interface nibble_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             sin;
  logic             sin_valid;
  logic             dir;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;

  modport slave (
    input  sin,
    input  sin_valid,
    input  dir,
    input  d_ready,
    output d,
    output d_valid
  );

  modport master (
    output sin,
    output sin_valid,
    output dir,
    output d_ready,
    input  d,
    input  d_valid
  );

endinterface

// File: rtl/deser_shreg.sv
// ---------------------------------------------------------------------------
// deser_shreg
// WIDTH-bit serial-in shift register; the sequential counterpart of the
// combinational shifter.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears q)
//   shift_en : shift one bit in this edge
//   dir      : DIR_MSB shifts left (new bit into q[0]),
//              DIR_LSB shifts right (new bit into q[WIDTH-1])
//   sin      : serial bit
//   q        : register contents
// ---------------------------------------------------------------------------
module deser_shreg
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      if (dir == DIR_LSB) begin
        q <= {sin, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], sin};
      end
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// ---------------------------------------------------------------------------
// nibble_deserializer
// Serial-in, parallel-out receiver. Reassembles WIDTH-bit words from an
// MSB-first or LSB-first bit stream and presents them on a single-entry
// valid/ready buffer, flagging overrun when a completed word must be dropped.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : nibble_deserializer_if.slave (sin, sin_valid, dir,
//                d, d_valid, d_ready)
//   clr_ovr    : synchronous clear of overrun
//   busy       : a word is partially received
//   overrun    : sticky, a completed word was dropped
//   parity_err : parity flag of the buffered word
//
// Configuration macro: DESER_PARITY_EN
//   defined   : each word is WIDTH data bits plus one even-parity bit
//   undefined : WIDTH data bits only, parity_err tied to 0
// ---------------------------------------------------------------------------
module nibble_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nibble_deserializer_if.slave   bus,
  input  logic                   clr_ovr,
  output logic                   busy,
  output logic                   overrun,
  output logic                   parity_err
);

`ifdef DESER_PARITY_EN
  localparam int WORD_BITS = WIDTH + 1;
`else
  localparam int WORD_BITS = WIDTH;
`endif
  localparam int            CW       = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORD_BITS - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic             dir_q;
  logic             first_bit;
  logic             last_bit;
  logic             shift_en;
  logic             shift_dir;
  logic             done_q;
  logic             handshake;
  logic [WIDTH-1:0] shreg_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a sampled bit starts a word, the final bit ends it.
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (bus.sin_valid) begin
        state_next = RECV;
      end
    end else begin
      if (bus.sin_valid && (count == LAST_CNT)) begin
        state_next = IDLE;
      end
    end
  end

  // FSM decode. The first bit of a word uses the live dir input because
  // dir_q is only being loaded on that same edge. With parity, the bit in
  // slot WIDTH is the parity bit and is kept out of the shift register.
  always_comb begin
    first_bit = (state == IDLE) && bus.sin_valid;
    last_bit  = (state == RECV) && bus.sin_valid && (count == LAST_CNT);
    shift_dir = (state == IDLE) ? bus.dir : dir_q;
`ifdef DESER_PARITY_EN
    shift_en  = bus.sin_valid && (count != CW'(WIDTH));
`else
    shift_en  = bus.sin_valid;
`endif
  end

  assign busy = (state == RECV);

  // Bit counter and latched word direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir_q <= DIR_MSB;
    end else if (first_bit) begin
      count <= CW'(1);
      dir_q <= bus.dir;
    end else if (last_bit) begin
      count <= '0;
    end else if ((state == RECV) && bus.sin_valid) begin
      count <= count + CW'(1);
    end
  end

  deser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .dir      (shift_dir),
    .sin      (bus.sin),
    .q        (shreg_q)
  );

  // Completion is registered so the buffer loads one edge after the final
  // bit. On that edge the shift register still holds the finished word even
  // if the first bit of the next word is shifting in, so no extra staging
  // register is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_bit;
    end
  end

`ifdef DESER_PARITY_EN
  logic par_acc;
  logic par_err_q;

  // Running XOR over data and parity bits; holds the word's result on the
  // edge after completion, when it is copied into the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
    end else if (first_bit) begin
      par_acc <= bus.sin;
    end else if ((state == RECV) && bus.sin_valid) begin
      par_acc <= par_acc ^ bus.sin;
    end
  end
`endif

  assign handshake = bus.d_valid && bus.d_ready;

  // Single-entry output buffer. A completed word is accepted when the
  // buffer is empty or is being drained on the same edge; otherwise it is
  // dropped and d keeps the unconsumed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.d       <= '0;
      bus.d_valid <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else if (done_q && (!bus.d_valid || bus.d_ready)) begin
      bus.d       <= shreg_q;
      bus.d_valid <= 1'b1;
`ifdef DESER_PARITY_EN
      par_err_q   <= par_acc;
`endif
    end else if (handshake) begin
      bus.d_valid <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end
  end

`ifdef DESER_PARITY_EN
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (done_q && bus.d_valid && !bus.d_ready) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// ---------------------------------------------------------------------------
// tb_nibble_deserializer
// Directed bench for nibble_deserializer (WIDTH = 4). Follows the build's
// DESER_PARITY_EN setting so words carry a parity bit when it is enabled.
// ---------------------------------------------------------------------------
module tb_nibble_deserializer;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  logic clr_ovr;
  logic busy;
  logic overrun;
  logic parity_err;

  int num_vectors;
  int num_miscompares;

  nibble_deserializer_if #(.WIDTH(WIDTH)) bus ();

  nibble_deserializer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_ovr    (clr_ovr),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison point; counts the vector and any miscompare.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    num_vectors++;
    assert (observed === expected)
    else begin
      num_miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one serial bit for a single edge; returns 1 ns after that edge.
  task automatic applyStimulus(input logic b, input logic dir_i);
    bus.sin       = b;
    bus.dir       = dir_i;
    bus.sin_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.sin_valid = 1'b0;
  endtask

  // Sends seq[3] first down to seq[0], plus correct even parity if enabled.
  task automatic sendWord(input logic [3:0] seq, input logic dir_i);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(seq[i], dir_i);
    end
`ifdef DESER_PARITY_EN
    applyStimulus(^seq, dir_i);
`endif
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    num_vectors     = 0;
    num_miscompares = 0;
    rst_n           = 1'b0;
    clr_ovr         = 1'b0;
    bus.sin         = 1'b0;
    bus.sin_valid   = 1'b0;
    bus.dir         = 1'b0;
    bus.d_ready     = 1'b0;

    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);

    // Reset state.
    checkOutput("rst_d",       8'(bus.d),       8'h0);
    checkOutput("rst_d_valid", 8'(bus.d_valid), 8'h0);
    checkOutput("rst_busy",    8'(busy),        8'h0);
    checkOutput("rst_overrun", 8'(overrun),     8'h0);
    checkOutput("rst_parity",  8'(parity_err),  8'h0);

    // Reset mid-word discards the partial word.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_busy_before", 8'(busy), 8'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_in_reset", 8'(busy), 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("mid_d_valid", 8'(bus.d_valid), 8'h0);
    sendWord(4'b1010, 1'b0);
    checkOutput("mid_latency", 8'(bus.d_valid), 8'h0);
    waitCycles(1);
    checkOutput("mid_d",       8'(bus.d),       8'h0A);
    checkOutput("mid_valid",   8'(bus.d_valid), 8'h1);
    bus.d_ready = 1'b1;
    waitCycles(1);
    checkOutput("mid_drained", 8'(bus.d_valid), 8'h0);

    // MSB first, consecutive bits, consumer ready.
    applyStimulus(1'b1, 1'b0);
    checkOutput("msb_busy", 8'(busy), 8'h1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
`ifdef DESER_PARITY_EN
    applyStimulus(1'b0, 1'b0);
`endif
    checkOutput("msb_idle",    8'(busy),        8'h0);
    checkOutput("msb_latency", 8'(bus.d_valid), 8'h0);
    waitCycles(1);
    checkOutput("msb_d",       8'(bus.d),       8'h0C);
    checkOutput("msb_valid",   8'(bus.d_valid), 8'h1);
    checkOutput("msb_parity",  8'(parity_err),  8'h0);
    waitCycles(1);
    checkOutput("msb_one_cycle", 8'(bus.d_valid), 8'h0);
    checkOutput("msb_d_held",    8'(bus.d),       8'h0C);

    // LSB first with a 3-cycle gap and dir toggling mid-word.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    bus.dir = 1'b0;
    waitCycles(3);
    checkOutput("lsb_gap_busy", 8'(busy), 8'h1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
`ifdef DESER_PARITY_EN
    applyStimulus(1'b0, 1'b0);
`endif
    waitCycles(1);
    checkOutput("lsb_d",     8'(bus.d),       8'h03);
    checkOutput("lsb_valid", 8'(bus.d_valid), 8'h1);
    waitCycles(1);
    checkOutput("lsb_drained", 8'(bus.d_valid), 8'h0);

    // Backpressure: second word is dropped and overrun sets.
    bus.d_ready = 1'b0;
    sendWord(4'b1001, 1'b0);
    sendWord(4'b0110, 1'b0);
    waitCycles(1);
    checkOutput("ovr_d",     8'(bus.d),       8'h09);
    checkOutput("ovr_valid", 8'(bus.d_valid), 8'h1);
    checkOutput("ovr_flag",  8'(overrun),     8'h1);
    clr_ovr = 1'b1;
    waitCycles(1);
    clr_ovr = 1'b0;
    checkOutput("ovr_cleared", 8'(overrun), 8'h0);
    checkOutput("ovr_d_kept",  8'(bus.d),   8'h09);

    // A new drop on the same edge as clr_ovr keeps overrun set.
    sendWord(4'b0101, 1'b0);
    clr_ovr = 1'b1;
    waitCycles(1);
    clr_ovr = 1'b0;
    checkOutput("ovr_set_wins", 8'(overrun), 8'h1);
    checkOutput("ovr_d_again",  8'(bus.d),   8'h09);
    clr_ovr = 1'b1;
    waitCycles(1);
    clr_ovr = 1'b0;
    checkOutput("ovr_cleared2", 8'(overrun), 8'h0);

    // Completion coincides with handshake of the previous word.
    bus.d_ready = 1'b1;
    waitCycles(1);
    checkOutput("hs_drain", 8'(bus.d_valid), 8'h0);
    bus.d_ready = 1'b0;
    sendWord(4'b1111, 1'b0);
    waitCycles(1);
    checkOutput("hs_first_d", 8'(bus.d), 8'h0F);
    sendWord(4'b0001, 1'b0);
    bus.d_ready = 1'b1;
    waitCycles(1);
    checkOutput("hs_d",       8'(bus.d),       8'h01);
    checkOutput("hs_valid",   8'(bus.d_valid), 8'h1);
    checkOutput("hs_overrun", 8'(overrun),     8'h0);
    waitCycles(1);
    checkOutput("hs_drained", 8'(bus.d_valid), 8'h0);

`ifdef DESER_PARITY_EN
    // Good parity: data 1011 (XOR 1) with parity bit 1.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    waitCycles(1);
    checkOutput("par_good_d",   8'(bus.d),      8'h0B);
    checkOutput("par_good_err", 8'(parity_err), 8'h0);
    waitCycles(1);
    // Bad parity: same data with parity bit 0; word still delivered.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitCycles(1);
    checkOutput("par_bad_d",     8'(bus.d),       8'h0B);
    checkOutput("par_bad_valid", 8'(bus.d_valid), 8'h1);
    checkOutput("par_bad_err",   8'(parity_err),  8'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
